intdiv_sd2_serializer: RTL and testbench
========================================

// Module: intdiv_sd2_serializer
// PURPOSE
//  Converts a W-bit operand into a serial, MSB-first stream of radix-2 signed digits (SD2)
//  for the digit-serial divider datapath, one digit per accepted beat.
//  Generalises the single-bit bit/sign->SD2 converter in two ways: W-bit width and a
//  two's-complement input mode. Valid/ready handshakes on both sides.
//  Sits between operand registers and the online divider's digit inputs.
// PARAMETERS
//  W      8   operand width in bits; legal range W >= 2
//  CNT_W  $clog2(W)   localparam; digit-index counter width
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand presented
//  in_ready   out  1      block can accept an operand
//  in_x       in   W      sign-magnitude: magnitude; two's-complement mode: full value
//  in_sign    in   1      sign for sign-magnitude mode (1 = negative); ignored in TC mode
//  in_mode    in   1      0 = sign-magnitude, 1 = two's complement
//  in_neg     in   1      negate result (present only with INTDIV_SD2SER_NEGATE_EN)
//  out_valid  out  1      out_digit/out_last are valid
//  out_ready  in   1      consumer takes the digit
//  out_digit  out  2      SD2 digit: NEG1=2'b11, ZERO=2'b00, POS1=2'b01 (only these emitted)
//  out_last   out  1      high with the final (LSB) digit of an operand
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, out_digit=ZERO, out_last=0, counter=W-1.
//  - FSM IDLE: in_ready=1. On in_valid&&in_ready, latch in_x/in_sign/in_mode (and in_neg),
//    set idx=W-1 and go to SHIFT.
//  - FSM SHIFT: in_ready=0, out_valid=1. The digit for bit idx is on out_digit.
//    On out_valid&&out_ready: if idx==0, go to IDLE; otherwise idx decrements.
//  - Latency: the first digit is valid on the cycle after input acceptance.
//    One operand takes exactly W transfer beats.
//  - After the last beat there is one IDLE cycle. There is no same-cycle reload.
//  - out_last=1 iff SHIFT && idx==0.
//  - Backpressure: while out_valid && !out_ready, out_digit, out_last and idx hold stable.
//  - Digit rule, sign-magnitude: bit=0 -> ZERO; bit=1,sign=0 -> POS1; bit=1,sign=1 -> NEG1.
//    Negative zero emits all ZERO digits.
//  - Digit rule, two's complement: bit W-1 has weight -2^(W-1), so bit=1 -> NEG1.
//    Bits W-2..0: bit=1 -> POS1. bit=0 -> ZERO at any position.
//  - Encoding 2'b10 (alternate POS1) is never driven. Don't-care codes are never driven.
//  - A reset during SHIFT aborts the stream: the next cycle is IDLE with out_valid=0.
//    No partial out_last is emitted.
//  - Input port values while in SHIFT are ignored. Latched values govern the whole stream.
// CONFIGURATION
//  INTDIV_SD2SER_NEGATE_EN defined:
//    - in_neg port exists and is latched on acceptance.
//    - If latched in_neg=1, every emitted digit has its polarity swapped:
//      POS1<->NEG1, ZERO stays ZERO. The stream value is negated with no carry.
//  Not defined:
//    - in_neg port is absent and digits are emitted unmodified.
// STRUCTURE
//  - SD2 codes NEG1/ZERO/POS1 come from the shared intdiv_sd2encoding definitions.
//    No local literals.
//  - Sub-module intdiv_sd2_digit (combinational): inputs bit, sign, msb_neg_weight, neg;
//    output 2-bit digit. Instanced once on the selected bit x_q[idx].
//  - Top level holds the FSM, the idx counter and the operand register.
// TESTING
//  1. W=4, SM, x=4'b1011, sign=0, out_ready=1 -> digits 01,00,01,01; out_last on 4th digit.
//  2. W=4, SM, x=4'b1011, sign=1 -> 11,00,11,11. x=4'b0000, sign=1 -> 00,00,00,00.
//  3. W=4, TC, x=4'b1011 (-5) -> 11,00,01,01. x=4'b0111 (+7) -> 00,01,01,01.
//  4. out_ready low for 3 cycles on digit 2 -> digit 00 held stable with out_valid=1.
//     Stream then resumes with no loss or duplication. in_ready stays 0 throughout.
//  5. reset asserted after 2 digits -> next cycle out_valid=0, in_ready=1.
//     A new operand then streams from the MSB.
//  6. NEGATE_EN, TC, x=4'b1011, neg=1 -> 01,00,11,11 (+5).
//     Without the macro, the same TC operand gives case 3's result.
//     Back-to-back in_valid -> exactly one IDLE cycle between streams.

Source files
------------

// File: rtl/intdiv_sd2_serializer_pkg.sv
// -----------------------------------------------------------------------------
// intdiv_sd2_serializer_pkg
// Shared radix-2 signed-digit (SD2) encoding for the intdiv digit-serial
// datapath, plus the serializer FSM state type.
//   SD2 codes : NEG1 = 2'b11, ZERO = 2'b00, POS1 = 2'b01
//   2'b10 is an alternate POS1 code and is never produced by this block.
// -----------------------------------------------------------------------------
package intdiv_sd2_serializer_pkg;

    typedef enum logic [1:0] {
        SD2_ZERO = 2'b00,
        SD2_POS1 = 2'b01,
        SD2_NEG1 = 2'b11
    } sd2_digit_e;

    // state    | meaning
    // ST_IDLE  | waiting for an operand, in_ready=1
    // ST_SHIFT | emitting digit idx of the latched operand, out_valid=1
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Polarity swap of one digit; ZERO maps to itself so no carry is needed.
    function automatic sd2_digit_e sd2_negate(input sd2_digit_e d);
        sd2_digit_e r;
        case (d)
            SD2_POS1: r = SD2_NEG1;
            SD2_NEG1: r = SD2_POS1;
            default:  r = SD2_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/intdiv_sd2_digit.sv
// -----------------------------------------------------------------------------
// intdiv_sd2_digit
// Combinational conversion of one operand bit into an SD2 digit.
// Ports:
//   bit_val        in  1  selected operand bit
//   sign           in  1  sign-magnitude sign (1 = negative); tie 0 in TC mode
//   msb_neg_weight in  1  bit carries weight -2^(W-1) (TC mode, MSB position)
//   neg            in  1  swap digit polarity
//   digit          out 2  SD2 code (NEG1/ZERO/POS1 only)
// -----------------------------------------------------------------------------
module intdiv_sd2_digit
    import intdiv_sd2_serializer_pkg::*;
(
    input  logic       bit_val,
    input  logic       sign,
    input  logic       msb_neg_weight,
    input  logic       neg,
    output logic [1:0] digit
);

    sd2_digit_e base;
    sd2_digit_e final_d;

    always_comb begin
        base = SD2_ZERO;
        if (bit_val) begin
            base = (sign || msb_neg_weight) ? SD2_NEG1 : SD2_POS1;
        end
        final_d = neg ? sd2_negate(base) : base;
        digit   = final_d;
    end

endmodule

// File: rtl/intdiv_sd2_serializer.sv
// -----------------------------------------------------------------------------
// intdiv_sd2_serializer
// Serializes a W-bit operand MSB-first into radix-2 signed digits, one digit
// per accepted output beat. Supports sign-magnitude and two's-complement
// operands. Optional result negation is enabled by defining the macro
// INTDIV_SD2SER_NEGATE_EN (adds the in_neg port).
// Ports:
//   clk        in  1  clock
//   reset      in  1  synchronous active-high reset
//   in_valid   in  1  operand presented
//   in_ready   out 1  block can accept an operand (IDLE)
//   in_x       in  W  magnitude (SM) or full value (TC)
//   in_sign    in  1  SM sign, ignored in TC mode
//   in_mode    in  1  0 = sign-magnitude, 1 = two's complement
//   in_neg     in  1  negate stream (only with INTDIV_SD2SER_NEGATE_EN)
//   out_valid  out 1  digit valid
//   out_ready  in  1  consumer takes the digit
//   out_digit  out 2  SD2 digit
//   out_last   out 1  final (LSB) digit of the operand
// -----------------------------------------------------------------------------
module intdiv_sd2_serializer
    import intdiv_sd2_serializer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic         in_sign,
    input  logic         in_mode,
`ifdef INTDIV_SD2SER_NEGATE_EN
    input  logic         in_neg,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_digit,
    output logic         out_last
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(W - 1);

    ser_state_e     state_q;
    ser_state_e     state_d;
    logic [CNT_W-1:0] idx_q;
    logic [W-1:0]   x_q;
    logic           sign_q;
    logic           mode_q;
    logic           neg_q;

    logic           accept;
    logic           beat;
    logic           idx_zero;
    logic [1:0]     cur_digit;

    assign accept   = in_valid && in_ready;
    assign beat     = out_valid && out_ready;
    assign idx_zero = (idx_q == '0);

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (beat && idx_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // outputs; out_digit is forced to ZERO outside SHIFT
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_digit = SD2_ZERO;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                out_valid = 1'b1;
                out_last  = idx_zero;
                out_digit = cur_digit;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // digit index: held while backpressured, reloaded to the MSB on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= IDX_MSB;
        end else if (accept) begin
            idx_q <= IDX_MSB;
        end else if (beat && !idx_zero) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    // operand register; only written on acceptance so inputs are ignored in SHIFT
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            sign_q <= 1'b0;
            mode_q <= 1'b0;
        end else if (accept) begin
            x_q    <= in_x;
            sign_q <= in_sign;
            mode_q <= in_mode;
        end
    end

`ifdef INTDIV_SD2SER_NEGATE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else if (accept) begin
            neg_q <= in_neg;
        end
    end
`else
    assign neg_q = 1'b0;
`endif

    // In TC mode the MSB weighs -2^(W-1); the SM sign is masked off there.
    intdiv_sd2_digit u_digit (
        .bit_val        (x_q[idx_q]),
        .sign           (sign_q && !mode_q),
        .msb_neg_weight (mode_q && (idx_q == IDX_MSB)),
        .neg            (neg_q),
        .digit          (cur_digit)
    );

endmodule

// File: tb/tb_intdiv_sd2_serializer.sv
module tb_intdiv_sd2_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic         in_sign;
    logic         in_mode;
    logic         in_neg;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_digit;
    logic         out_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    intdiv_sd2_serializer #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_sign   (in_sign),
        .in_mode   (in_mode),
`ifdef INTDIV_SD2SER_NEGATE_EN
        .in_neg    (in_neg),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last)
    );

`ifdef INTDIV_SD2SER_NEGATE_EN
    localparam bit NEG_EN = 1'b1;
`else
    localparam bit NEG_EN = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, $signed(act), $signed(exp), $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_digit(input logic [W-1:0] x, input logic s, input logic m,
                                     input logic n, input int i);
        int d;
        if (!x[i])      d = 0;
        else if (m)     d = (i == W - 1) ? -1 : 1;
        else            d = s ? -1 : 1;
        if (n && NEG_EN) d = -d;
        return d;
    endfunction

    function automatic int exp_value(input logic [W-1:0] x, input logic s, input logic m,
                                     input logic n);
        int v;
        if (m) v = x[W-1] ? int'(x) - (1 << W) : int'(x);
        else   v = s ? -int'(x) : int'(x);
        if (n && NEG_EN) v = -v;
        return v;
    endfunction

    function automatic int decode(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 99;
        endcase
    endfunction

    function automatic logic [2*W-1:0] model_codes(input logic [W-1:0] x, input logic s,
                                                   input logic m, input logic n);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            int d;
            d = exp_digit(x, s, m, n, i);
            r = {r[2*W-3:0], (d == -1) ? 2'b11 : (d == 1) ? 2'b01 : 2'b00};
        end
        return r;
    endfunction

    int q_exp[$];
    int cur_val;
    int acc;
    bit seen_rst = 1'b0;

    // compare against the model, then advance it with the inputs about to be clocked
    always @(negedge clk) begin
        if (seen_rst) begin
            chk("in_ready", in_ready, q_exp.size() == 0);
            chk("out_valid", out_valid, q_exp.size() != 0);
            if (q_exp.size() != 0) begin
                chk("out_digit", decode(out_digit), q_exp[0]);
                chk("out_last", out_last, q_exp.size() == 1);
            end else begin
                chk("idle_digit", out_digit, 2'b00);
                chk("idle_last", out_last, 1'b0);
            end
        end
        if (reset) begin
            q_exp.delete();
            seen_rst = 1'b1;
        end else if (q_exp.size() == 0) begin
            if (in_valid) begin
                for (int i = W - 1; i >= 0; i--)
                    q_exp.push_back(exp_digit(in_x, in_sign, in_mode, in_neg, i));
                cur_val = exp_value(in_x, in_sign, in_mode, in_neg);
                acc = 0;
            end
        end else if (out_ready) begin
            acc += decode(out_digit) * (1 << (q_exp.size() - 1));
            void'(q_exp.pop_front());
            if (q_exp.size() == 0) chk("stream_value", acc, cur_val);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [W-1:0] x, input logic s, input logic m, input logic n);
        in_valid = 1'b1; in_x = x; in_sign = s; in_mode = m; in_neg = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready === 1'b1 && out_valid === 1'b0) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        int zeros;
        logic ov [0:2*W];
        reset = 1'b1; in_valid = 1'b0; in_x = '0; in_sign = 1'b0; in_mode = 1'b0;
        in_neg = 1'b0; out_ready = 1'b1;

        // pin the model to hand-computed digit strings
        chk("model_sm_pos", model_codes(4'b1011, 0, 0, 0), 8'b01_00_01_01);
        chk("model_sm_neg", model_codes(4'b1011, 1, 0, 0), 8'b11_00_11_11);
        chk("model_sm_negzero", model_codes(4'b0000, 1, 0, 0), 8'b00_00_00_00);
        chk("model_tc_m5", model_codes(4'b1011, 0, 1, 0), 8'b11_00_01_01);
        chk("model_tc_p7", model_codes(4'b0111, 0, 1, 0), 8'b00_01_01_01);
        chk("model_tc_neg", model_codes(4'b1011, 0, 1, 1),
            NEG_EN ? 8'b01_00_11_11 : 8'b11_00_01_01);
        chk("model_val_tc", exp_value(4'b1011, 0, 1, 0), -5);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);

        send(4'b1011, 0, 0, 0); wait_idle();
        send(4'b1011, 1, 0, 0); wait_idle();
        send(4'b0000, 1, 0, 0); wait_idle();
        send(4'b1011, 0, 1, 0); wait_idle();
        send(4'b0111, 0, 1, 0); wait_idle();
        send(4'b1011, 0, 1, 1); wait_idle();

        // backpressure on the second digit
        send(4'b1011, 0, 0, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_digit", out_digit, 2'b00);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        wait_idle();

        // reset mid-stream
        send(4'b0111, 0, 1, 0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        send(4'b1011, 1, 0, 0); wait_idle();

        // back-to-back operands: exactly one idle cycle between streams
        in_valid = 1'b1; in_x = 4'b1001; in_sign = 1'b0; in_mode = 1'b1; in_neg = 1'b0;
        for (int c = 0; c <= 2 * W; c++) begin
            @(posedge clk); #1;
            ov[c] = out_valid;
        end
        in_valid = 1'b0;
        zeros = 0;
        for (int c = 0; c <= 2 * W; c++) if (ov[c] !== 1'b1) zeros++;
        chk("b2b_idle_gap", zeros, 1);
        chk("b2b_gap_pos", ov[W], 1'b0);
        wait_idle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_x      = W'($urandom_range(0, (1 << W) - 1));
            in_sign   = 1'($urandom_range(0, 1));
            in_mode   = 1'($urandom_range(0, 1));
            in_neg    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
